// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: sequences N_TAPS (a,w,b) operand fetches through one multiply-add lane and returns sum(a*w+b).
// Optional NEURON_SEQ_SAT_EN makes both additions saturate instead of wrapping.
module neuron_seq_ctrl #(
   parameter int WIDTH  = 32,
   parameter int N_TAPS = 9,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              op_rd,
   output logic [ADDR_W-1:0] op_addr,
   input  logic [WIDTH-1:0]  a_in,
   input  logic [WIDTH-1:0]  w_in,
   input  logic [WIDTH-1:0]  b_in,
   output logic [WIDTH-1:0]  sum_out,
   output logic              out_valid,
   input  logic              out_ready
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TAPS - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] idx;
   logic              rd_d;
   logic [WIDTH-1:0]  acc, prod, term, acc_nxt;

   function automatic logic [WIDTH-1:0] add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH:0] s;
      s = {x[WIDTH-1], x} + {y[WIDTH-1], y};
`ifdef NEURON_SEQ_SAT_EN
      return (s[WIDTH] != s[WIDTH-1]) ? {s[WIDTH], {(WIDTH-1){~s[WIDTH]}}} : s[WIDTH-1:0];
`else
      return s[WIDTH-1:0];
`endif
   endfunction

   always_comb begin
      prod    = WIDTH'($signed(a_in) * $signed(w_in));
      term    = add(prod, b_in);
      acc_nxt = add(acc, term);
   end

   assign op_rd     = state == FETCH;
   assign op_addr   = idx;
   assign busy      = state != IDLE;
   assign out_valid = state == DONE;
   assign sum_out   = acc;

   // rd_d marks the cycle the operand store returns the triple addressed last cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         rd_d  <= 1'b0;
         acc   <= '0;
      end else begin
         rd_d <= state == FETCH;
         if (rd_d) acc <= acc_nxt;
         case (state)
            IDLE: if (start) begin
               state <= FETCH;
               idx   <= '0;
               acc   <= '0;
            end
            FETCH: if (idx == LAST) state <= DRAIN;
                   else idx <= idx + 1'b1;
            DRAIN: state <= DONE;
            default: if (out_ready) state <= IDLE;
         endcase
      end
   end
endmodule
